pico_mem_responder: RTL and testbench
=====================================

Name: pico_mem_responder

Overview:
- Responder (slave) end of the picorv32 native memory interface (mem_valid/mem_ready handshake).
- Sits between a picorv32 core and an internal word-organised RAM.
- Provides parameterised read and write wait states, a run-time stall input, byte-strobe writes, out-of-range error reporting and access counters.
- Used as the standard memory model and small on-chip RAM for synthesis and simulation tops.

Parameters:
- MEM_WORDS, 1024, number of 32-bit RAM words.
- ADDR_BASE, 32'h0000_0000, byte address of word 0; must be word-aligned.
- READ_WAIT, 1, extra cycles inserted before mem_ready on reads (0..15).
- WRITE_WAIT, 0, extra cycles inserted before mem_ready on writes (0..15).
- ERR_RDATA, 32'hDEAD_BEEF, read data returned for out-of-range reads.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_valid  input  1  initiator request valid.
- mem_instr  input  1  request is an instruction fetch.
- mem_ready  output  1  single-cycle completion pulse.
- mem_addr  input  32  byte address; bits [1:0] are ignored.
- mem_wdata  input  32  write data.
- mem_wstrb  input  4  byte write enables; 0 means read.
- mem_rdata  output  32  read data, held stable between reads.
- stall  input  1  while high, holds the wait counter (adds wait cycles).
- bus_err  output  1  sticky out-of-range flag.
- err_addr  output  32  mem_addr of the first out-of-range access.
- rd_count  output  16  completed reads, wrapping.
- wr_count  output  16  completed writes, wrapping.
- fetch_count  output  16  completed reads with mem_instr=1, wrapping.

Behaviour:
- Reset (synchronous, active-high) sets state IDLE, mem_ready=0, mem_rdata=0, bus_err=0, err_addr=0, all counters 0. RAM contents are not reset.
- States are IDLE, WAIT, RESP, GAP.
- IDLE:
  - When mem_valid=1, latch addr, wdata, wstrb and instr.
  - Load wcnt = (wstrb!=0) ? WRITE_WAIT : READ_WAIT.
  - Go to WAIT.
- WAIT:
  - If mem_valid=0 (protocol abort), go to IDLE with no write, no ready and no count.
  - Otherwise, if stall=1, hold.
  - Otherwise, if wcnt==0, go to RESP; else decrement wcnt.
- RESP:
  - mem_ready=1 for exactly this one cycle.
  - Reads: mem_rdata is loaded at the clock edge entering RESP.
  - Writes: committed at the clock edge leaving RESP.
  - The counter increments when leaving RESP.
  - Next state is GAP.
- GAP: mem_ready=0 and mem_valid is ignored for one cycle (the initiator deasserts valid here). Next state is IDLE.
- Latency: with valid first sampled at edge k and stall=0, mem_ready is high in cycle k+2+N, where N = READ_WAIT or WRITE_WAIT. Each stall-high cycle in WAIT adds one cycle.
- Minimum transaction spacing is N+4 cycles.
- Decode:
  - off = addr - ADDR_BASE; idx = off[31:2].
  - The access is in range iff addr >= ADDR_BASE and idx < MEM_WORDS.
- Write, in range: update byte lane i iff wstrb[i]; untouched lanes keep their value. wstrb=4'b0000 is a read.
- Read, in range: mem_rdata = RAM[idx].
- Out of range:
  - The handshake completes with identical latency.
  - Reads return ERR_RDATA; writes are dropped.
  - bus_err is set and stays set until reset.
  - err_addr is captured only when bus_err was 0.
- mem_rdata changes only on read completion; writes and idle cycles leave it unchanged (LATCHED_MEM_RDATA-safe).
- Counters:
  - Increment on completion, including out-of-range accesses.
  - Aborted transactions are not counted.
  - Counters wrap 16'hFFFF -> 0.
- Reset asserted in any state returns to IDLE on the next edge. An uncommitted write (not yet leaving RESP) is discarded, and mem_ready is 0 the following cycle.
- The block never asserts mem_ready unless a transaction was accepted.

Test Plan:
- Read latency: RAM[3]=32'h1234_5678, READ_WAIT=1; read addr 0x0C, valid sampled at edge 0 -> mem_ready high only in cycle 3; mem_rdata=32'h1234_5678, held after valid drops; rd_count=1.
- Byte strobes: RAM[0]=32'hAABB_CCDD; write wdata=32'h1122_3344, wstrb=4'b0101 -> subsequent read returns 32'hAA22_CC44; wr_count=1; ready one cycle after acceptance (WRITE_WAIT=0).
- Stall: READ_WAIT=2, stall high for 3 cycles during WAIT -> ready delayed by exactly 3 cycles versus the unstalled case; single-cycle pulse.
- Out of range:
  - MEM_WORDS=1024, read addr 0x1000 -> rdata 32'hDEAD_BEEF, bus_err=1, err_addr=0x1000.
  - Then write to 0x2000 -> dropped, err_addr still 0x1000, wr_count increments.
- Abort/reset:
  - Drop mem_valid in WAIT -> no ready, counters unchanged.
  - Assert reset while a write is in WAIT -> RAM word unchanged, all outputs at reset values next cycle.
- Back-to-back with picorv32 (LATCHED_MEM_RDATA=1) running a fetch/load/store loop -> fetch_count equals the number of instructions retired; RAM matches the golden model.

Source files
------------

// File: rtl/pico_mem_responder.sv
// pico_mem_responder: responder end of the picorv32 native memory bus.
// Word-organised RAM with read/write wait states, a stall input, byte-strobe
// writes, sticky out-of-range error capture and wrapping access counters.
//   clk, reset          : clock, synchronous active-high reset
//   mem_valid/mem_ready : request valid in, one-cycle completion pulse out
//   mem_instr           : request is an instruction fetch
//   mem_addr/wdata/wstrb: byte address, write data, byte enables (0 = read)
//   mem_rdata           : read data, changes only when a read completes
//   stall               : holds the wait counter while high
//   bus_err/err_addr    : sticky out-of-range flag and first offending address
//   rd/wr/fetch_count   : completed reads, writes and instruction fetches
module pico_mem_responder #(
    parameter int unsigned MEM_WORDS  = 1024,
    parameter logic [31:0] ADDR_BASE  = 32'h0000_0000,
    parameter int unsigned READ_WAIT  = 1,
    parameter int unsigned WRITE_WAIT = 0,
    parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    input  logic        stall,
    output logic        bus_err,
    output logic [31:0] err_addr,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic [15:0] fetch_count
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [29:0] BASE_W = ADDR_BASE[31:2];

    typedef enum logic [1:0] {IDLE, WAIT, RESP, GAP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;
    logic [31:0] rdata_q;
    logic        bus_err_q;
    logic [31:0] err_addr_q;
    logic [15:0] rd_cnt_q, wr_cnt_q, fetch_cnt_q;
    logic [31:0] ram_q [MEM_WORDS];

    logic          accept, enter_resp, leave_resp;
    logic          is_read, in_range;
    logic [29:0]   word_off;
    logic [AW-1:0] idx;

    // Word offset from the base; ADDR_BASE is word aligned so the low
    // address bits never take part in the decode.
    assign word_off = addr_q[31:2] - BASE_W;
    assign idx      = word_off[AW-1:0];
    assign in_range = (addr_q >= ADDR_BASE)
                   && ({2'b00, word_off} < 32'(MEM_WORDS));
    assign is_read  = (wstrb_q == 4'b0000);

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        leave_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    accept  = 1'b1;
                    state_d = WAIT;
                    wcnt_d  = (mem_wstrb != 4'b0000) ? 4'(WRITE_WAIT)
                                                     : 4'(READ_WAIT);
                end
            end
            WAIT: begin
                // Initiator withdrawing valid aborts without side effects.
                if (!mem_valid) begin
                    state_d = IDLE;
                end else if (!stall) begin
                    if (wcnt_q == 4'd0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q - 4'd1;
                    end
                end
            end
            RESP: begin
                leave_resp = 1'b1;
                state_d    = GAP;
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wcnt_q      <= 4'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wstrb_q     <= 4'd0;
            instr_q     <= 1'b0;
            rdata_q     <= 32'd0;
            bus_err_q   <= 1'b0;
            err_addr_q  <= 32'd0;
            rd_cnt_q    <= 16'd0;
            wr_cnt_q    <= 16'd0;
            fetch_cnt_q <= 16'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (accept) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
                instr_q <= mem_instr;
            end
            if (enter_resp) begin
                if (is_read) begin
                    rdata_q <= in_range ? ram_q[idx] : ERR_RDATA;
                end
                if (!in_range) begin
                    bus_err_q <= 1'b1;
                    if (!bus_err_q) begin
                        err_addr_q <= addr_q;
                    end
                end
            end
            if (leave_resp) begin
                if (is_read) begin
                    rd_cnt_q <= rd_cnt_q + 16'd1;
                    if (instr_q) begin
                        fetch_cnt_q <= fetch_cnt_q + 16'd1;
                    end
                end else begin
                    wr_cnt_q <= wr_cnt_q + 16'd1;
                end
            end
        end
    end

    // RAM is not reset; a reset during RESP discards the pending write.
    always_ff @(posedge clk) begin
        if (!reset && leave_resp && !is_read && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    ram_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign mem_ready   = (state_q == RESP);
    assign mem_rdata   = rdata_q;
    assign bus_err     = bus_err_q;
    assign err_addr    = err_addr_q;
    assign rd_count    = rd_cnt_q;
    assign wr_count    = wr_cnt_q;
    assign fetch_count = fetch_cnt_q;

endmodule

// File: tb/tb_pico_mem_responder.sv
// tb_pico_mem_responder: directed and randomized checks of the responder
// against a word-array reference model of the memory bus rules.
module tb_pico_mem_responder;

    localparam int          WORDS = 1024;
    localparam int          RW    = 1;
    localparam int          WW    = 0;
    localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_instr;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        bus_err;
    logic [31:0] err_addr;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic [15:0] fetch_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] mdl [WORDS];
    logic [31:0] m_rdata;
    logic        m_err;
    logic [31:0] m_err_addr;
    logic [15:0] m_rd, m_wr, m_fetch;

    pico_mem_responder #(
        .MEM_WORDS (WORDS),
        .ADDR_BASE (32'h0000_0000),
        .READ_WAIT (RW),
        .WRITE_WAIT(WW),
        .ERR_RDATA (ERRD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .stall      (stall),
        .bus_err    (bus_err),
        .err_addr   (err_addr),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rdata    = 32'd0;
        m_err      = 1'b0;
        m_err_addr = 32'd0;
        m_rd       = 16'd0;
        m_wr       = 16'd0;
        m_fetch    = 16'd0;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".rdata"}, mem_rdata, m_rdata);
        chk({tag, ".rd_count"}, 32'(rd_count), 32'(m_rd));
        chk({tag, ".wr_count"}, 32'(wr_count), 32'(m_wr));
        chk({tag, ".fetch_count"}, 32'(fetch_count), 32'(m_fetch));
        chk({tag, ".bus_err"}, 32'(bus_err), 32'(m_err));
        chk({tag, ".err_addr"}, err_addr, m_err_addr);
    endtask

    // One full transaction; called right after a negedge with the DUT idle.
    task automatic txn(input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input logic ins, input int s,
                       input string tag);
        int          lat;
        int          exp_lat;
        logic [31:0] rd_seen;
        logic        inr;
        int          wi;
        rd_seen   = 32'd0;
        mem_addr  = a;
        mem_wdata = wd;
        mem_wstrb = ws;
        mem_instr = ins;
        mem_valid = 1'b1;
        stall     = 1'b0;
        exp_lat   = 2 + ((ws != 4'd0) ? WW : RW) + s;
        lat       = 0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            if (mem_ready) begin
                lat     = c;
                rd_seen = mem_rdata;
            end
            stall = (c <= s);
        end
        stall     = 1'b0;
        mem_valid = 1'b0;
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));

        inr = (a < 32'(WORDS * 4));
        wi  = int'(a[31:2]);
        if (ws == 4'd0) begin
            m_rdata = inr ? mdl[wi] : ERRD;
            m_rd++;
            if (ins) m_fetch++;
        end else begin
            if (inr) begin
                for (int b = 0; b < 4; b++) begin
                    if (ws[b]) mdl[wi][8*b +: 8] = wd[8*b +: 8];
                end
            end
            m_wr++;
        end
        if (!inr) begin
            if (!m_err) m_err_addr = a;
            m_err = 1'b1;
        end
        if (ws == 4'd0 && lat != 0) chk({tag, ".rdata_at_ready"}, rd_seen, m_rdata);

        @(negedge clk);
        chk({tag, ".ready_pulse"}, 32'(mem_ready), 32'd0);
        @(negedge clk);
        chk_status(tag);
    endtask

    task automatic abort_txn(input logic [31:0] a);
        mem_addr  = a;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        mem_instr = 1'b0;
        mem_valid = 1'b1;
        @(negedge clk);
        chk("abort.ready_wait", 32'(mem_ready), 32'd0);
        mem_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort.no_ready", 32'(mem_ready), 32'd0);
        end
        chk_status("abort");
    endtask

    initial begin
        logic [31:0] a, d;
        logic [3:0]  ws;
        int          s;

        reset     = 1'b1;
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'd0;
        stall     = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset.ready", 32'(mem_ready), 32'd0);
        chk_status("reset");
        repeat (3) begin
            @(negedge clk);
            chk("idle.ready", 32'(mem_ready), 32'd0);
        end

        // Preload a working set through the bus.
        for (int i = 0; i < 16; i++) begin
            txn(32'(i * 4), $urandom, 4'hF, 1'b0, 0, "init");
        end
        txn(32'h0000_000C, 32'h1234_5678, 4'hF, 1'b0, 0, "init3");
        txn(32'h0000_0000, 32'hAABB_CCDD, 4'hF, 1'b0, 0, "init0");
        txn(32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 1'b0, 0, "init_last");

        txn(32'h0000_000C, 32'd0, 4'd0, 1'b1, 0, "read3");
        chk("read3.value", mem_rdata, 32'h1234_5678);

        txn(32'h0000_0000, 32'h1122_3344, 4'b0101, 1'b0, 0, "strb_wr");
        txn(32'h0000_0000, 32'd0, 4'd0, 1'b0, 0, "strb_rd");
        chk("strb.value", mem_rdata, 32'hAA22_CC44);

        txn(32'h0000_0008, 32'd0, 4'd0, 1'b0, 3, "stall_rd");
        txn(32'h0000_0004, 32'h5A5A_5A5A, 4'b1000, 1'b0, 2, "stall_wr");

        txn(32'h0000_0FFC, 32'd0, 4'd0, 1'b0, 0, "last_word");
        chk("last_word.value", mem_rdata, 32'hCAFE_F00D);

        txn(32'h0000_1000, 32'd0, 4'd0, 1'b0, 0, "oor_rd");
        chk("oor_rd.err_addr", err_addr, 32'h0000_1000);
        txn(32'h0000_2000, 32'hFFFF_FFFF, 4'hF, 1'b0, 0, "oor_wr");
        chk("oor_wr.err_addr", err_addr, 32'h0000_1000);

        abort_txn(32'h0000_0014);

        // Reset while a write waits: write discarded, outputs cleared.
        d         = 32'h0BAD_0BAD;
        mem_addr  = 32'h0000_001C;
        mem_wdata = d;
        mem_wstrb = 4'hF;
        mem_instr = 1'b0;
        mem_valid = 1'b1;
        stall     = 1'b1;
        @(negedge clk);
        chk("rst_wait.ready", 32'(mem_ready), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        mem_valid = 1'b0;
        stall     = 1'b0;
        model_reset();
        chk("rst_wait.ready_after", 32'(mem_ready), 32'd0);
        chk_status("rst_wait");
        txn(32'h0000_001C, 32'd0, 4'd0, 1'b0, 0, "rst_wait_rd");

        // Randomized traffic against the model.
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) == 0)
                a = 32'h0000_1000 + 32'($urandom_range(0, 255) * 4);
            else
                a = 32'($urandom_range(0, 15) * 4);
            ws = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
            s  = $urandom_range(0, 3);
            txn(a, $urandom, ws, 1'($urandom), s, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
